// File: rtl/cfg_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_frame_tx
//  Description : Four-line start-marker serializer for the VREF/DATA/CONVER/
//                COMP configuration shift registers.
//  Revision    : 1.0  initial release
// ============================================================================
module cfg_frame_tx #(
    parameter int W_VREF = 4,
    parameter int W_DATA = 8,
    parameter int W_CONV = 8,
    parameter int W_COMP = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [W_VREF-1:0] vref_word,
    input  logic [W_DATA-1:0] data_word,
    input  logic [W_CONV-1:0] conver_word,
    input  logic [W_COMP-1:0] comp_word,
    output logic              tx_vref,
    output logic              tx_data,
    output logic              tx_conver,
    output logic              tx_comp,
    output logic              busy,
    output logic              done
);

    localparam int c_W_AB = (W_VREF > W_DATA) ? W_VREF : W_DATA;
    localparam int c_W_CD = (W_CONV > W_COMP) ? W_CONV : W_COMP;
    localparam int c_WMAX = (c_W_AB > c_W_CD) ? c_W_AB : c_W_CD;
    localparam int c_CW   = $clog2(c_WMAX + 1);
    localparam logic [c_CW-1:0] c_K_LAST = c_CW'(c_WMAX);
    localparam logic [c_CW-1:0] c_K_ONE  = c_CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_CW-1:0]   r_k;
    logic [c_CW-1:0]   w_k_nxt;

    // Each line's frame is held as {payload, marker}; bit 0 drives the line,
    // so the line output comes straight from a flop.
    logic [W_VREF:0]   r_sr_vref;
    logic [W_VREF:0]   w_sr_vref_nxt;
    logic [W_DATA:0]   r_sr_data;
    logic [W_DATA:0]   w_sr_data_nxt;
    logic [W_CONV:0]   r_sr_conv;
    logic [W_CONV:0]   w_sr_conv_nxt;
    logic [W_COMP:0]   r_sr_comp;
    logic [W_COMP:0]   w_sr_comp_nxt;

    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_ready;
    logic              w_ready_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_k       <= '0;
            r_sr_vref <= '0;
            r_sr_data <= '0;
            r_sr_conv <= '0;
            r_sr_comp <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_sr_vref <= w_sr_vref_nxt;
            r_sr_data <= w_sr_data_nxt;
            r_sr_conv <= w_sr_conv_nxt;
            r_sr_comp <= w_sr_comp_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_k_nxt       = r_k;
        w_sr_vref_nxt = r_sr_vref;
        w_sr_data_nxt = r_sr_data;
        w_sr_conv_nxt = r_sr_conv;
        w_sr_comp_nxt = r_sr_comp;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_ready_nxt   = r_ready;

        case (r_state)
            ST_IDLE: begin
                if (start_valid) begin
                    w_state_nxt   = ST_SEND;
                    w_k_nxt       = '0;
                    w_sr_vref_nxt = {vref_word,   1'b1};
                    w_sr_data_nxt = {data_word,   1'b1};
                    w_sr_conv_nxt = {conver_word, 1'b1};
                    w_sr_comp_nxt = {comp_word,   1'b1};
                    w_busy_nxt    = 1'b1;
                    w_ready_nxt   = 1'b0;
                end
            end
            ST_SEND: begin
                if (r_k == c_K_LAST) begin
                    w_state_nxt   = ST_FIN;
                    w_sr_vref_nxt = '0;
                    w_sr_data_nxt = '0;
                    w_sr_conv_nxt = '0;
                    w_sr_comp_nxt = '0;
                    w_done_nxt    = 1'b1;
                end else begin
                    // Zeros fill from the top so short frames idle low early.
                    w_k_nxt       = r_k + c_K_ONE;
                    w_sr_vref_nxt = {1'b0, r_sr_vref[W_VREF:1]};
                    w_sr_data_nxt = {1'b0, r_sr_data[W_DATA:1]};
                    w_sr_conv_nxt = {1'b0, r_sr_conv[W_CONV:1]};
                    w_sr_comp_nxt = {1'b0, r_sr_comp[W_COMP:1]};
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_k_nxt       = '0;
                w_sr_vref_nxt = '0;
                w_sr_data_nxt = '0;
                w_sr_conv_nxt = '0;
                w_sr_comp_nxt = '0;
                w_busy_nxt    = 1'b0;
                w_ready_nxt   = 1'b1;
            end
        endcase
    end

    assign tx_vref     = r_sr_vref[0];
    assign tx_data     = r_sr_data[0];
    assign tx_conver   = r_sr_conv[0];
    assign tx_comp     = r_sr_comp[0];
    assign busy        = r_busy;
    assign done        = r_done;
    assign start_ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_cfg_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cfg_frame_tx
//  Description : Directed bench for cfg_frame_tx with receiver loopback models.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cfg_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_valid;
    logic       start_ready;
    logic [3:0] vref_word;
    logic [7:0] data_word;
    logic [7:0] conver_word;
    logic [5:0] comp_word;
    logic       tx_vref, tx_data, tx_conver, tx_comp;
    logic       busy, done;

    int n_checks = 0;
    int n_errors = 0;

    logic       rx_clr = 1'b0;
    logic [4:0] rx_v;
    logic [8:0] rx_d;
    logic [8:0] rx_c;
    logic [6:0] rx_p;

    wire [3:0] lines = {tx_vref, tx_data, tx_conver, tx_comp};

    cfg_frame_tx dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .vref_word   (vref_word),
        .data_word   (data_word),
        .conver_word (conver_word),
        .comp_word   (comp_word),
        .tx_vref     (tx_vref),
        .tx_data     (tx_data),
        .tx_conver   (tx_conver),
        .tx_comp     (tx_comp),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Marker-terminated receivers: shift in at the top, freeze once marker hits bit 0.
    always @(posedge clk) begin
        if (rx_clr) begin
            rx_v <= '0; rx_d <= '0; rx_c <= '0; rx_p <= '0;
        end else begin
            if (!rx_v[0]) rx_v <= {tx_vref,   rx_v[4:1]};
            if (!rx_d[0]) rx_d <= {tx_data,   rx_d[8:1]};
            if (!rx_c[0]) rx_c <= {tx_conver, rx_c[8:1]};
            if (!rx_p[0]) rx_p <= {tx_comp,   rx_p[6:1]};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic fbit(input logic [7:0] w, input int width, input int k);
        if (k == 0) return 1'b1;
        if (k <= width) return w[k-1];
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_lines(input logic [3:0] v, input logic [7:0] d,
                                             input logic [7:0] c, input logic [5:0] p,
                                             input int k);
        return {fbit({4'h0, v}, 4, k), fbit(d, 8, k), fbit(c, 8, k), fbit({2'b00, p}, 6, k)};
    endfunction

    // Accept a frame, check every line cycle against the model and the loopback result.
    task automatic run_frame(input string tag, input logic [3:0] v, input logic [7:0] d,
                             input logic [7:0] c, input logic [5:0] p);
        rx_clr = 1'b1;
        vref_word = v; data_word = d; conver_word = c; comp_word = p;
        start_valid = 1'b1;
        tick();
        rx_clr = 1'b0;
        start_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            chk({tag, "_lines"}, {28'h0, lines}, {28'h0, exp_lines(v, d, c, p, k - 1)});
            chk({tag, "_busy"}, {31'h0, busy}, 32'h1);
            tick();
        end
        chk({tag, "_done"}, {31'h0, done}, 32'h1);
        tick();
        chk({tag, "_rx_v"}, {27'h0, rx_v}, {27'h0, v, 1'b1});
        chk({tag, "_rx_d"}, {23'h0, rx_d}, {23'h0, d, 1'b1});
        chk({tag, "_rx_c"}, {23'h0, rx_c}, {23'h0, c, 1'b1});
        chk({tag, "_rx_p"}, {25'h0, rx_p}, {25'h0, p, 1'b1});
        chk({tag, "_ready"}, {31'h0, start_ready}, 32'h1);
    endtask

    initial begin
        logic [8:0] e_v, e_d, e_c, e_p;
        int done_cnt;
        int m_t[3], d_t[3];
        int m_n, d_n, waited;
        logic prev_busy;

        rst = 1'b1; start_valid = 1'b0;
        vref_word = '0; data_word = '0; conver_word = '0; comp_word = '0;
        repeat (5) tick();
        chk("rst_lines", {28'h0, lines}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        rst = 1'b0;
        tick();
        chk("idle_ready", {31'h0, start_ready}, 32'h1);
        for (int i = 0; i < 20; i++) begin
            chk("idle_quiet", {26'h0, busy, done, lines}, 32'h0);
            tick();
        end

        // Hand-derived patterns for cycles 1..9 (bit i = cycle i+1).
        e_v = 9'h015; e_d = 9'h079; e_c = 9'h1E1; e_p = 9'h02B;
        vref_word = 4'hA; data_word = 8'h3C; conver_word = 8'hF0; comp_word = 6'h15;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            chk("single_vref", {31'h0, tx_vref},   {31'h0, e_v[c-1]});
            chk("single_data", {31'h0, tx_data},   {31'h0, e_d[c-1]});
            chk("single_conv", {31'h0, tx_conver}, {31'h0, e_c[c-1]});
            chk("single_comp", {31'h0, tx_comp},   {31'h0, e_p[c-1]});
            chk("single_stat", {29'h0, busy, done, start_ready}, 32'h4);
            tick();
        end
        chk("single_fin", {26'h0, busy, done, lines}, 32'h30);
        tick();
        chk("single_after", {29'h0, busy, done, start_ready}, 32'h1);

        for (int i = 0; i < 50; i++)
            run_frame("loop", 4'($urandom), 8'($urandom), 8'($urandom), 6'($urandom));

        // Busy-ignore: new requests and changing data during SEND must not disturb the frame.
        vref_word = 4'h3; data_word = 8'hA5; conver_word = 8'h0F; comp_word = 6'h2A;
        start_valid = 1'b1;
        tick();
        done_cnt = 0;
        data_word = 8'h55;
        for (int c = 1; c <= 9; c++) begin
            chk("ign_ready", {31'h0, start_ready}, 32'h0);
            chk("ign_data", {31'h0, tx_data}, {31'h0, fbit(8'hA5, 8, c - 1)});
            if (done) done_cnt++;
            tick();
            data_word = 8'($urandom);
        end
        start_valid = 1'b0;
        for (int c = 10; c <= 16; c++) begin
            if (done) done_cnt++;
            tick();
        end
        chk("ign_done_count", done_cnt, 1);
        chk("ign_idle", {30'h0, busy, start_ready}, 32'h1);

        // Back-to-back with start_valid held high.
        vref_word = 4'h9; data_word = 8'h81; conver_word = 8'h42; comp_word = 6'h21;
        start_valid = 1'b1;
        m_n = 0; d_n = 0; prev_busy = busy;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (busy && !prev_busy && m_n < 3) begin
                chk("b2b_marker", {28'h0, lines}, 32'hF);
                m_t[m_n] = t; m_n++;
            end
            if (done && d_n < 3) begin
                d_t[d_n] = t; d_n++;
            end
            prev_busy = busy;
        end
        start_valid = 1'b0;
        chk("b2b_m_count", m_n, 3);
        chk("b2b_d_count", d_n, 3);
        if (m_n == 3 && d_n == 3) begin
            chk("b2b_m_gap0", m_t[1] - m_t[0], 11);
            chk("b2b_m_gap1", m_t[2] - m_t[1], 11);
            chk("b2b_d_gap0", d_t[1] - d_t[0], 11);
            chk("b2b_d_gap1", d_t[2] - d_t[1], 11);
            chk("b2b_latency", d_t[0] - m_t[0], 9);
        end
        waited = 0;
        while (!(start_ready && !busy) && waited < 20) begin
            tick();
            waited++;
        end
        chk("b2b_drain_timeout", {31'h0, (waited < 20)}, 32'h1);
        tick();

        // Reset asserted asynchronously while k = 4.
        vref_word = 4'hF; data_word = 8'hFF; conver_word = 8'hFF; comp_word = 6'h3F;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        repeat (4) tick();
        chk("mid_pre_lines", {28'h0, lines}, 32'hF);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_async_lines", {28'h0, lines}, 32'h0);
        chk("mid_async_busy", {31'h0, busy}, 32'h0);
        tick();
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_cnt++;
            tick();
        end
        chk("mid_no_done", done_cnt, 0);
        chk("mid_ready", {31'h0, start_ready}, 32'h1);
        run_frame("post_rst", 4'h6, 8'hC3, 8'h5A, 6'h0D);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
